sample_collector: RTL

//  Downstream consumer of the pincontrol sample bus. Round-robins channel_select over up to 8 pin

---
 rtl/sample_collector.sv | 236 +++++++++++++++++++++++
 1 files changed

// File: rtl/sample_collector.sv
// sample_collector: round-robin pincontrol sampler that keeps only new samples in an EBI-drained FIFO.
// Optional define SAMPLE_TIMESTAMP_EN adds current_time and appends a timestamp word to each sample.
module sample_collector #(
  parameter logic [7:0] POSITION      = 8'hF0,
  parameter logic [7:0] FIRST_CHANNEL = 8'h00,
  parameter int         NUM_CHANNELS  = 8,
  parameter int         FIFO_DEPTH    = 64
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  input  logic [18:0] addr,
  input  logic        data_wr,
  input  logic        data_rd,
  input  logic [15:0] data_in,
  output logic [15:0] data_out,
  output logic        output_sample,
  output logic [7:0]  channel_select,
  input  logic [31:0] sample_data,
`ifdef SAMPLE_TIMESTAMP_EN
  input  logic [31:0] current_time,
`endif
  output logic        fifo_not_empty
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
  localparam logic [7:0] SLOT_MASK = 8'((9'h1 << NUM_CHANNELS) - 9'h1);

  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_WAIT, S_CAP,
`ifdef SAMPLE_TIMESTAMP_EN
    S_CAP2,
`endif
    S_NEXT
  } state_t;

  state_t           state_q, state_d;
  logic [2:0]       slot_q, slot_d;
  logic             scan_en_q, scan_en_d;
  logic [7:0]       mask_q, mask_d;
  logic             ovf_q, ovf_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [15:0]      data_out_q, data_out_d;
  logic [14:0]      last_cnt_q [8];
  logic [14:0]      last_cnt_d [8];
  logic [15:0]      mem_q [FIFO_DEPTH];
`ifdef SAMPLE_TIMESTAMP_EN
  logic [15:0]      ts_q, ts_d;
  logic             ts_pend_q, ts_pend_d;
  logic [CNT_W-1:0] free;
`endif

  logic        sel, wr_en, rd_en, flush, pop, push, ovf_set;
  logic        word_ok, accept;
  logic [7:0]  reg_a, eff_mask;
  logic [14:0] s_cnt;
  logic [15:0] cap_word, push_word;
  logic [6:0]  cnt_sat;
  logic        unused_ok;

  // First MASK-enabled slot at (incl) or after (!incl) cur, wrapping at NUM_CHANNELS.
  function automatic logic [2:0] pick_slot(input logic [2:0] cur, input logic [7:0] m,
                                           input logic incl);
    logic [2:0] r;
    logic       found;
    int         idx;
    r = cur;
    found = 1'b0;
    for (int k = 0; k < NUM_CHANNELS; k++) begin
      idx = (int'(cur) + k + (incl ? 0 : 1)) % NUM_CHANNELS;
      if (!found && m[idx[2:0]]) begin
        found = 1'b1;
        r = idx[2:0];
      end
    end
    return r;
  endfunction

  assign sel      = enable && (addr[15:8] == POSITION);
  assign reg_a    = addr[7:0];
  assign wr_en    = sel && data_wr;
  assign rd_en    = sel && data_rd;
  assign flush    = wr_en && (reg_a == 8'd0) && data_in[1];
  assign pop      = rd_en && (reg_a == 8'd3) && (count_q != '0);
  assign eff_mask = mask_q & SLOT_MASK;

  assign s_cnt    = sample_data[30:16];
  assign word_ok  = (sample_data[15:4] == 12'hABC) && (sample_data[3:1] == 3'b111);
  assign accept   = (state_q == S_CAP) && word_ok && (s_cnt != last_cnt_q[slot_q]);
  assign cap_word = {channel_select, s_cnt[6:0], sample_data[0]};

  assign output_sample  = (state_q == S_REQ);
  assign channel_select = FIRST_CHANNEL + {5'b0, slot_q};
  assign fifo_not_empty = (count_q != '0);
  assign data_out       = data_out_q;

`ifdef SAMPLE_TIMESTAMP_EN
  assign unused_ok = ^{addr[18:16], data_in[15:8], sample_data[31], current_time[31:16]};
`else
  assign unused_ok = ^{addr[18:16], data_in[15:8], sample_data[31]};
`endif

  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    case (state_q)
      S_IDLE: if (scan_en_q && (eff_mask != 8'h0)) begin
        state_d = S_REQ;
        slot_d  = pick_slot(slot_q, eff_mask, 1'b1);
      end
      S_REQ:  state_d = S_WAIT;
      S_WAIT: state_d = S_CAP;
`ifdef SAMPLE_TIMESTAMP_EN
      S_CAP:  state_d = S_CAP2;
      S_CAP2: state_d = S_NEXT;
`else
      S_CAP:  state_d = S_NEXT;
`endif
      S_NEXT: if (!scan_en_q || (eff_mask == 8'h0)) begin
        state_d = S_IDLE;
      end else begin
        state_d = S_REQ;
        slot_d  = pick_slot(slot_q, eff_mask, 1'b0);
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    push       = 1'b0;
    push_word  = cap_word;
    ovf_set    = 1'b0;
    last_cnt_d = last_cnt_q;
    if (accept) last_cnt_d[slot_q] = s_cnt;
`ifdef SAMPLE_TIMESTAMP_EN
    // The data word and its timestamp go in back to back, so room for both is reserved up front.
    free      = DEPTH_C - count_q;
    ts_d      = ts_q;
    ts_pend_d = 1'b0;
    if (state_q == S_CAP) ts_d = current_time[15:0];
    if (accept) begin
      if (free >= CNT_W'(2)) begin
        push      = 1'b1;
        ts_pend_d = !flush;
      end else begin
        ovf_set = 1'b1;
      end
    end
    if ((state_q == S_CAP2) && ts_pend_q) begin
      push      = 1'b1;
      push_word = ts_q;
    end
`else
    if (accept) begin
      if ((count_q != DEPTH_C) || pop) push = 1'b1;
      else ovf_set = 1'b1;
    end
`endif
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_comb begin
    scan_en_d = scan_en_q;
    mask_d    = mask_q;
    ovf_d     = ovf_q;
    if (wr_en && (reg_a == 8'd0)) scan_en_d = data_in[0];
    if (wr_en && (reg_a == 8'd1)) mask_d = data_in[7:0];
    if (wr_en && (reg_a == 8'd2)) ovf_d = 1'b0;
    if (ovf_set) ovf_d = 1'b1;
    cnt_sat    = (int'(count_q) > 127) ? 7'h7F : 7'(count_q);
    data_out_d = 16'h0;
    if (rd_en) begin
      case (reg_a)
        8'd0: data_out_d = {15'h0, scan_en_q};
        8'd1: data_out_d = {8'h0, mask_q};
        8'd2: data_out_d = {ovf_q, 8'h0, cnt_sat};
        8'd3: if (count_q != '0) data_out_d = mem_q[rd_ptr_q];
        default: data_out_d = 16'h0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      slot_q     <= 3'd0;
      scan_en_q  <= 1'b0;
      mask_q     <= 8'hFF;
      ovf_q      <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      data_out_q <= 16'h0;
      for (int i = 0; i < 8; i++) last_cnt_q[i] <= 15'h0;
`ifdef SAMPLE_TIMESTAMP_EN
      ts_q       <= 16'h0;
      ts_pend_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      slot_q     <= slot_d;
      scan_en_q  <= scan_en_d;
      mask_q     <= mask_d;
      ovf_q      <= ovf_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      data_out_q <= data_out_d;
      last_cnt_q <= last_cnt_d;
`ifdef SAMPLE_TIMESTAMP_EN
      ts_q       <= ts_d;
      ts_pend_q  <= ts_pend_d;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) mem_q[wr_ptr_q] <= push_word;
  end
endmodule
